// File: rtl/sargantana_icache_flush_seq_if.sv
// Purpose: port bundle for the icache valid-bit flush sequencer. It carries the
//          flush handshake from the icache controller, the refill valid-bit write
//          request and grant, the valid-array write port, and status outputs.
// Modports:
//   slave  - the sequencer: takes flush/fill requests, drives grant, array
//            write port, busy, done and flush count
//   master - the environment: drives requests, observes everything else
interface sargantana_icache_flush_seq_if #(
    parameter int unsigned IDX_WIDTH = 6,
    parameter int unsigned N_WAY     = 4
);
    logic                 flush_req_i;
    logic                 fill_wr_req_i;
    logic [IDX_WIDTH-1:0] fill_wr_idx_i;
    logic [N_WAY-1:0]     fill_wr_way_i;
    logic                 fill_wr_gnt_o;
    logic                 vbit_wr_en_o;
    logic [IDX_WIDTH-1:0] vbit_wr_idx_o;
    logic [N_WAY-1:0]     vbit_wr_mask_o;
    logic                 vbit_wr_data_o;
    logic                 busy_o;
    logic                 flush_done_o;
    logic [15:0]          flush_cnt_o;

    modport slave (
        input  flush_req_i,
        input  fill_wr_req_i,
        input  fill_wr_idx_i,
        input  fill_wr_way_i,
        output fill_wr_gnt_o,
        output vbit_wr_en_o,
        output vbit_wr_idx_o,
        output vbit_wr_mask_o,
        output vbit_wr_data_o,
        output busy_o,
        output flush_done_o,
        output flush_cnt_o
    );

    modport master (
        output flush_req_i,
        output fill_wr_req_i,
        output fill_wr_idx_i,
        output fill_wr_way_i,
        input  fill_wr_gnt_o,
        input  vbit_wr_en_o,
        input  vbit_wr_idx_o,
        input  vbit_wr_mask_o,
        input  vbit_wr_data_o,
        input  busy_o,
        input  flush_done_o,
        input  flush_cnt_o
    );
endinterface

// File: rtl/sargantana_icache_flush_seq.sv
// Purpose: walks every set of the icache valid-bit array on a flush request,
//          clearing all ways one index per cycle, then pulses flush_done_o for
//          one cycle. Owns the single valid-array write port and arbitrates it
//          between the flush walk and refill valid-bit writes (refill stalls
//          while a walk is in progress).
// Ports:
//   clk_i  - clock, rising edge
//   rstn_i - asynchronous active-low reset
//   bus    - slave side of sargantana_icache_flush_seq_if (flush request,
//            refill write request/grant, valid-array write port, busy, done,
//            completed-flush count)
// Build option: define ICACHE_FLUSH_CNT_EN to build a saturating 16-bit
//               completed-flush counter; otherwise flush_cnt_o is tied to 0.
module sargantana_icache_flush_seq #(
    parameter int unsigned IDX_WIDTH = 6,
    parameter int unsigned N_WAY     = 4
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    sargantana_icache_flush_seq_if.slave  bus
);
    localparam int unsigned N_SETS   = 2 ** IDX_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_SETS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state;
    logic [IDX_WIDTH-1:0] idx;
    logic                 armed;

    // Sequencer state; armed re-arms only once the request has been seen low,
    // so a request held across completion cannot start a second walk.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
            idx   <= '0;
            armed <= 1'b1;
        end else begin
            if (!bus.flush_req_i) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.flush_req_i && armed) begin
                        state <= WALK;
                        idx   <= '0;
                        armed <= 1'b0;
                    end
                end
                WALK: begin
                    idx <= idx + IDX_WIDTH'(1);
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Write-port mux and status decode; depends only on state, idx and the
    // fill inputs. Reset gating keeps every output at 0 while rstn_i is low.
    always_comb begin
        bus.fill_wr_gnt_o  = 1'b0;
        bus.vbit_wr_en_o   = 1'b0;
        bus.vbit_wr_idx_o  = '0;
        bus.vbit_wr_mask_o = '0;
        bus.vbit_wr_data_o = 1'b0;
        bus.busy_o         = 1'b0;
        bus.flush_done_o   = 1'b0;
        case (state)
            IDLE: begin
                if (rstn_i && bus.fill_wr_req_i) begin
                    bus.fill_wr_gnt_o  = 1'b1;
                    bus.vbit_wr_en_o   = 1'b1;
                    bus.vbit_wr_idx_o  = bus.fill_wr_idx_i;
                    bus.vbit_wr_mask_o = bus.fill_wr_way_i;
                    bus.vbit_wr_data_o = 1'b1;
                end
            end
            WALK: begin
                bus.vbit_wr_en_o   = 1'b1;
                bus.vbit_wr_idx_o  = idx;
                bus.vbit_wr_mask_o = '1;
                bus.busy_o         = 1'b1;
            end
            DONE: begin
                bus.flush_done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef ICACHE_FLUSH_CNT_EN
    logic [15:0] flush_cnt;

    // Completed-flush counter, saturating at all ones.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            flush_cnt <= '0;
        end else if (state == DONE && flush_cnt != 16'hFFFF) begin
            flush_cnt <= flush_cnt + 16'd1;
        end
    end

    assign bus.flush_cnt_o = flush_cnt;
`else
    assign bus.flush_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_sargantana_icache_flush_seq.sv
// Directed bench for sargantana_icache_flush_seq with IDX_WIDTH=3 (8 sets),
// N_WAY=4. Inputs change 1 time unit after each rising edge; outputs are
// checked 1 time unit later, well away from the next edge.
module tb_sargantana_icache_flush_seq;
    localparam int unsigned IDX_WIDTH = 3;
    localparam int unsigned N_WAY     = 4;
    localparam int unsigned N_SETS    = 8;
`ifdef ICACHE_FLUSH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;

    sargantana_icache_flush_seq_if #(.IDX_WIDTH(IDX_WIDTH), .N_WAY(N_WAY)) bus_if ();

    sargantana_icache_flush_seq #(
        .IDX_WIDTH (IDX_WIDTH),
        .N_WAY     (N_WAY)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    // Checks one walk write cycle for set index i.
    task automatic chk_walk(input string tag, input int i);
        chk({tag, "_en"},   32'(bus_if.vbit_wr_en_o),   32'd1);
        chk({tag, "_idx"},  32'(bus_if.vbit_wr_idx_o),  32'(i));
        chk({tag, "_mask"}, 32'(bus_if.vbit_wr_mask_o), 32'hF);
        chk({tag, "_data"}, 32'(bus_if.vbit_wr_data_o), 32'd0);
        chk({tag, "_busy"}, 32'(bus_if.busy_o),         32'd1);
        chk({tag, "_done"}, 32'(bus_if.flush_done_o),   32'd0);
    endtask

    initial begin
        int dones;
        int busy_cycles;
        int wait_cnt;

        // Reset with a fill request already present: everything must read 0.
        rstn                 = 1'b0;
        bus_if.flush_req_i   = 1'b0;
        bus_if.fill_wr_req_i = 1'b1;
        bus_if.fill_wr_idx_i = 3'd5;
        bus_if.fill_wr_way_i = 4'b0010;
        #2;
        chk("rst_gnt",  32'(bus_if.fill_wr_gnt_o),  32'd0);
        chk("rst_en",   32'(bus_if.vbit_wr_en_o),   32'd0);
        chk("rst_mask", 32'(bus_if.vbit_wr_mask_o), 32'd0);
        chk("rst_busy", 32'(bus_if.busy_o),         32'd0);
        chk("rst_done", 32'(bus_if.flush_done_o),   32'd0);
        chk("rst_cnt",  32'(bus_if.flush_cnt_o),    32'd0);
        tick();
        tick();
        rstn = 1'b1;
        #1;

        // Idle fill is granted in the same cycle.
        chk("fill_gnt",  32'(bus_if.fill_wr_gnt_o),  32'd1);
        chk("fill_en",   32'(bus_if.vbit_wr_en_o),   32'd1);
        chk("fill_idx",  32'(bus_if.vbit_wr_idx_o),  32'd5);
        chk("fill_mask", 32'(bus_if.vbit_wr_mask_o), 32'h2);
        chk("fill_data", 32'(bus_if.vbit_wr_data_o), 32'd1);
        tick();
        bus_if.fill_wr_req_i = 1'b0;

        // One-cycle flush pulse: cycle 0 sample, walk 1..8, done at 9.
        bus_if.flush_req_i = 1'b1;
        #1;
        chk("p_c0_busy", 32'(bus_if.busy_o), 32'd0);
        tick();
        bus_if.flush_req_i = 1'b0;
        for (int i = 0; i < int'(N_SETS); i++) begin
            #1;
            chk_walk("p_walk", i);
            tick();
        end
        #1;
        chk("p_c9_done", 32'(bus_if.flush_done_o), 32'd1);
        chk("p_c9_busy", 32'(bus_if.busy_o),       32'd0);
        chk("p_c9_en",   32'(bus_if.vbit_wr_en_o), 32'd0);
        tick();
        #1;
        chk("p_c10_done", 32'(bus_if.flush_done_o), 32'd0);
        chk("p_cnt1",     32'(bus_if.flush_cnt_o),  exp_cnt(1));

        // Fill held across a flush: granted at cycle 0, stalled 1..9, granted at 10.
        bus_if.fill_wr_req_i = 1'b1;
        bus_if.fill_wr_idx_i = 3'd6;
        bus_if.fill_wr_way_i = 4'b1000;
        bus_if.flush_req_i   = 1'b1;
        #1;
        chk("h_c0_gnt", 32'(bus_if.fill_wr_gnt_o), 32'd1);
        tick();
        bus_if.flush_req_i = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            #1;
            chk("h_stall_gnt", 32'(bus_if.fill_wr_gnt_o), 32'd0);
            if (c <= 8) begin
                chk("h_walk_idx",  32'(bus_if.vbit_wr_idx_o),  32'(c - 1));
                chk("h_walk_data", 32'(bus_if.vbit_wr_data_o), 32'd0);
            end
            tick();
        end
        #1;
        chk("h_c10_gnt",  32'(bus_if.fill_wr_gnt_o),  32'd1);
        chk("h_c10_idx",  32'(bus_if.vbit_wr_idx_o),  32'd6);
        chk("h_c10_mask", 32'(bus_if.vbit_wr_mask_o), 32'h8);
        chk("h_c10_data", 32'(bus_if.vbit_wr_data_o), 32'd1);
        bus_if.fill_wr_req_i = 1'b0;
        tick();

        // Request held 20 cycles: exactly one walk (8 busy cycles) and one done.
        bus_if.flush_req_i = 1'b1;
        dones       = 0;
        busy_cycles = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus_if.flush_done_o === 1'b1) dones++;
            if (bus_if.busy_o === 1'b1) busy_cycles++;
            tick();
        end
        chk("held_dones", 32'(dones),       32'd1);
        chk("held_busy",  32'(busy_cycles), 32'd8);
        chk("held_cnt3",  32'(bus_if.flush_cnt_o), exp_cnt(3));

        // Drop for one cycle and raise again: a new walk starts.
        bus_if.flush_req_i = 1'b0;
        tick();
        bus_if.flush_req_i = 1'b1;
        #1;
        chk("rearm_c0_busy", 32'(bus_if.busy_o), 32'd0);
        tick();
        bus_if.flush_req_i = 1'b0;
        #1;
        chk_walk("rearm_walk0", 0);
        wait_cnt = 0;
        while (bus_if.flush_done_o !== 1'b1 && wait_cnt < 20) begin
            tick();
            #1;
            wait_cnt++;
        end
        chk("rearm_done_lat", 32'(wait_cnt), 32'd8);
        tick();
        #1;
        chk("rearm_cnt4", 32'(bus_if.flush_cnt_o), exp_cnt(4));

        // Reset in the middle of a walk at idx 3.
        bus_if.flush_req_i = 1'b1;
        tick();
        bus_if.flush_req_i = 1'b0;
        tick();
        tick();
        tick();
        #1;
        chk_walk("mid_idx3", 3);
        rstn = 1'b0;
        #1;
        chk("mid_rst_en",   32'(bus_if.vbit_wr_en_o),  32'd0);
        chk("mid_rst_idx",  32'(bus_if.vbit_wr_idx_o), 32'd0);
        chk("mid_rst_busy", 32'(bus_if.busy_o),        32'd0);
        chk("mid_rst_done", 32'(bus_if.flush_done_o),  32'd0);
        chk("mid_rst_cnt",  32'(bus_if.flush_cnt_o),   32'd0);
        tick();
        rstn = 1'b1;
        dones       = 0;
        busy_cycles = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bus_if.flush_done_o === 1'b1) dones++;
            if (bus_if.busy_o === 1'b1) busy_cycles++;
            tick();
        end
        chk("post_rst_dones", 32'(dones),       32'd0);
        chk("post_rst_busy",  32'(busy_cycles), 32'd0);

        // Fresh request after reset yields a full 0..7 walk and a done pulse.
        bus_if.flush_req_i = 1'b1;
        tick();
        bus_if.flush_req_i = 1'b0;
        for (int i = 0; i < int'(N_SETS); i++) begin
            #1;
            chk_walk("fresh_walk", i);
            tick();
        end
        #1;
        chk("fresh_done", 32'(bus_if.flush_done_o), 32'd1);
        tick();
        #1;
        chk("fresh_cnt1", 32'(bus_if.flush_cnt_o), exp_cnt(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
